// File: rtl/particle_pkg.sv
// Shared types, field layout and saturation helper for the particle kinematics datapath.
package particle_pkg;

    typedef logic signed [15:0] fix16_t;

    typedef struct packed {
        fix16_t pos_x;
        fix16_t pos_y;
        fix16_t vel_x;
        fix16_t vel_y;
    } particle_t;

    localparam int FIELD_W   = 16;
    localparam int POS_X_LSB = 48;
    localparam int POS_Y_LSB = 32;
    localparam int VEL_X_LSB = 16;
    localparam int VEL_Y_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        CALC,
        EMIT,
        DONE
    } integ_state_t;

    function automatic fix16_t sat16(input logic signed [16:0] x);
        if (x > 17'sd32767)
            return 16'sh7FFF;
        else if (x < -17'sd32768)
            return 16'sh8000;
        else
            return x[15:0];
    endfunction

endpackage

// File: rtl/particle_axis_step.sv
// One axis of gravity + explicit-Euler step, with wall clamp and damped reflection.
module particle_axis_step
    import particle_pkg::*;
#(
    parameter fix16_t G          = 16'sd0,
    parameter int     DT_SHIFT   = 2,
    parameter int     DAMP_SHIFT = 1,
    parameter fix16_t BOUND_MAX  = 16'sh7F00
) (
    input  fix16_t p_in,
    input  fix16_t v_in,
    output fix16_t p_out,
    output fix16_t v_out
);

    logic signed [16:0] v_sum;
    logic signed [16:0] p_sum;
    logic signed [16:0] v_neg;
    fix16_t             v1;
    fix16_t             p1;
    fix16_t             step;

    always_comb begin
        v_sum = $signed({v_in[15], v_in}) + $signed({G[15], G});
        v1    = sat16(v_sum);
        step  = v1 >>> DT_SHIFT;
        p_sum = $signed({p_in[15], p_in}) + $signed({step[15], step});
        p1    = sat16(p_sum);
        // 17-bit negate so that -(-32768) saturates instead of wrapping
        v_neg = -($signed({v1[15], v1}) >>> DAMP_SHIFT);
        p_out = p1;
        v_out = v1;
        if (p1 < 16'sd0) begin
            p_out = 16'sd0;
            v_out = sat16(v_neg);
        end else if (p1 > BOUND_MAX) begin
            p_out = BOUND_MAX;
            v_out = sat16(v_neg);
        end
    end

endmodule

// File: rtl/particle_integrator.sv
// Per-frame particle integrator: read, latch, compute, emit one particle every four cycles,
// then pulse activate so the downstream buffer can copy results back.
module particle_integrator
    import particle_pkg::*;
#(
    parameter int     ADDR_WIDTH = 7,
    parameter int     RAM_WIDTH  = 64,
    parameter fix16_t GRAVITY    = -16'sd16,
    parameter int     DT_SHIFT   = 2,
    parameter int     DAMP_SHIFT = 1,
    parameter fix16_t BOUND_MAX  = 16'sh7F00
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   particle_count,
    input  logic                  done_swapping,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [RAM_WIDTH-1:0]  rd_data,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [RAM_WIDTH-1:0]  mem_out,
    output logic                  data_valid_out,
    output logic                  activate,
    output logic                  busy
);

    integ_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   idx_next;
    logic                  accept;
    logic                  last;

    logic [RAM_WIDTH-1:0]  word_p0;
    particle_t             in_p1;
    particle_t             out_p1;

    assign rd_addr  = idx_q;
    assign accept   = (state_q == IDLE) && start && done_swapping;
    assign idx_next = {1'b0, idx_q} + (ADDR_WIDTH+1)'(1);
    assign last     = (idx_next >= count_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (particle_count != '0) ? READ : DONE;
            READ:    state_d = LATCH;
            LATCH:   state_d = CALC;
            CALC:    state_d = EMIT;
            EMIT:    state_d = last ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // LATCH stage: capture the buffer word addressed during READ
    always_ff @(posedge clk_in) begin
        if (state_q == LATCH)
            word_p0 <= rd_data;
    end

    // CALC stage: unpack, step both axes, repack
    assign in_p1.pos_x = word_p0[POS_X_LSB +: FIELD_W];
    assign in_p1.pos_y = word_p0[POS_Y_LSB +: FIELD_W];
    assign in_p1.vel_x = word_p0[VEL_X_LSB +: FIELD_W];
    assign in_p1.vel_y = word_p0[VEL_Y_LSB +: FIELD_W];

    particle_axis_step #(
        .G(16'sd0), .DT_SHIFT(DT_SHIFT), .DAMP_SHIFT(DAMP_SHIFT), .BOUND_MAX(BOUND_MAX)
    ) u_axis_x (
        .p_in(in_p1.pos_x), .v_in(in_p1.vel_x), .p_out(out_p1.pos_x), .v_out(out_p1.vel_x)
    );

    particle_axis_step #(
        .G(GRAVITY), .DT_SHIFT(DT_SHIFT), .DAMP_SHIFT(DAMP_SHIFT), .BOUND_MAX(BOUND_MAX)
    ) u_axis_y (
        .p_in(in_p1.pos_y), .v_in(in_p1.vel_y), .p_out(out_p1.pos_y), .v_out(out_p1.vel_y)
    );

    // EMIT stage: outputs registered on the CALC->EMIT edge
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            count_q        <= '0;
            addr_out       <= '0;
            mem_out        <= '0;
            data_valid_out <= 1'b0;
            activate       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy           <= (state_d != IDLE);
            activate       <= (state_d == DONE);
            data_valid_out <= (state_d == EMIT);
            if (accept) begin
                idx_q   <= '0;
                count_q <= particle_count;
            end else if (state_q == EMIT) begin
                idx_q <= idx_q + ADDR_WIDTH'(1);
            end
            if (state_q == CALC) begin
                addr_out <= idx_q;
                mem_out  <= RAM_WIDTH'(out_p1);
            end
        end
    end

endmodule

// File: tb/tb_particle_integrator.sv
// Scoreboard bench for particle_integrator with a behavioural integer model of the kinematics.
module tb_particle_integrator;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  particle_count;
    logic        done_swapping;
    logic [6:0]  rd_addr;
    logic [63:0] rd_data;
    logic [6:0]  addr_out;
    logic [63:0] mem_out;
    logic        data_valid_out;
    logic        activate;
    logic        busy;

    logic [63:0] mem [128];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [6:0]  addr;
        logic [63:0] word;
    } exp_t;

    exp_t wr_q[$];
    int   act_q[$];
    int   busy_lo = 1;
    int   busy_hi = 0;

    always #5 clk_in = ~clk_in;

    particle_integrator dut (
        .clk_in(clk_in), .rst_n(rst_n), .start(start), .particle_count(particle_count),
        .done_swapping(done_swapping), .rd_addr(rd_addr), .rd_data(rd_data),
        .addr_out(addr_out), .mem_out(mem_out), .data_valid_out(data_valid_out),
        .activate(activate), .busy(busy)
    );

    always @(posedge clk_in) begin
        cyc     <= cyc + 1;
        rd_data <= mem[rd_addr];
    end

    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic void axis(input int p, input int v, input int g, output int po, output int vo);
        int v1, p1;
        v1 = sat(v + g);
        p1 = sat(p + (v1 >>> 2));
        if (p1 < 0) begin
            po = 0;
            vo = sat(-(v1 >>> 1));
        end else if (p1 > 32512) begin
            po = 32512;
            vo = sat(-(v1 >>> 1));
        end else begin
            po = p1;
            vo = v1;
        end
    endfunction

    function automatic logic [63:0] ref_word(input logic [63:0] w);
        int px, py, vx, vy;
        px = $signed(w[63:48]);
        py = $signed(w[47:32]);
        vx = $signed(w[31:16]);
        vy = $signed(w[15:0]);
        axis(px, vx, 0, px, vx);
        axis(py, vy, -16, py, vy);
        return {px[15:0], py[15:0], vx[15:0], vy[15:0]};
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endfunction

    always @(negedge clk_in) begin
        if (rst_n) begin
            while (wr_q.size() != 0 && wr_q[0].cyc < cyc) begin
                check("missing_strobe", 64'(0), 64'(wr_q[0].cyc));
                void'(wr_q.pop_front());
            end
            while (act_q.size() != 0 && act_q[0] < cyc) begin
                check("missing_activate", 64'(0), 64'(act_q[0]));
                void'(act_q.pop_front());
            end
            if (data_valid_out) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_strobe", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = wr_q.pop_front();
                    check("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    check("addr_out", 64'(addr_out), 64'(e.addr));
                    check("mem_out", mem_out, e.word);
                end
            end
            if (activate) begin
                if (act_q.size() == 0)
                    check("unexpected_activate", 64'(1), 64'(0));
                else
                    check("activate_cycle", 64'(cyc), 64'(act_q.pop_front()));
            end
            check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    task automatic issue(input int n, input bit ds, input bit use_const,
                         input logic [63:0] const_exp, output int t);
        @(posedge clk_in);
        #1;
        done_swapping  = ds;
        start          = 1'b1;
        particle_count = 8'(n);
        t              = cyc;
        if (ds) begin
            for (int i = 0; i < n; i++)
                wr_q.push_back('{t + 4 + 4 * i, 7'(i), use_const ? const_exp : ref_word(mem[i])});
            act_q.push_back(t + 4 * n + 1);
            busy_lo = t + 1;
            busy_hi = t + 4 * n + 1;
        end
        @(posedge clk_in);
        #1;
        start = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++)
            mem[i] = {$urandom(), $urandom()};
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'(0));
        check({tag, "_addr_out"}, 64'(addr_out), 64'(0));
        check({tag, "_mem_out"}, mem_out, 64'(0));
        check({tag, "_valid"}, 64'(data_valid_out), 64'(0));
        check({tag, "_activate"}, 64'(activate), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int t;
        int n;
        rst_n          = 1'b0;
        start          = 1'b0;
        particle_count = '0;
        done_swapping  = 1'b1;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        #2;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk_in);

        mem[0] = 64'h0064_0064_0000_0000;
        issue(1, 1'b1, 1'b1, 64'h0064_0060_0000_FFF0, t);
        repeat (7) @(posedge clk_in);

        mem[0] = 64'h1000_0002_0000_FFD8;
        issue(1, 1'b1, 1'b1, 64'h1000_0000_0000_001C, t);
        repeat (7) @(posedge clk_in);

        mem[0] = 64'h7D00_1000_7FFF_0000;
        issue(1, 1'b1, 1'b1, 64'h7F00_0FFC_C001_FFF0, t);
        repeat (7) @(posedge clk_in);

        fill(4);
        issue(4, 1'b1, 1'b0, '0, t);
        repeat (5) @(posedge clk_in);
        #1;
        start          = 1'b1;
        particle_count = 8'd3;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk_in);

        issue(3, 1'b0, 1'b0, '0, t);
        repeat (20) @(posedge clk_in);

        issue(0, 1'b1, 1'b0, '0, t);
        repeat (4) @(posedge clk_in);

        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 9);
            fill(n);
            issue(n, 1'b1, 1'b0, '0, t);
            repeat (4 * n + 3) @(posedge clk_in);
        end

        fill(128);
        issue(128, 1'b1, 1'b0, '0, t);
        repeat (4 * 128 + 3) @(posedge clk_in);

        fill(4);
        issue(4, 1'b1, 1'b0, '0, t);
        repeat (8) @(posedge clk_in);
        #1;
        rst_n   = 1'b0;
        busy_hi = 0;
        #1;
        check_outputs_zero("midreset");
        wr_q.delete();
        act_q.delete();
        repeat (3) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk_in);

        fill(2);
        issue(2, 1'b1, 1'b0, '0, t);
        repeat (12) @(posedge clk_in);

        check("strobes_left", 64'(wr_q.size()), 64'(0));
        check("activates_left", 64'(act_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
